// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: alignment check, word-aligned memory port,
// read-modify-write for sub-word stores, sign/zero-extended load results.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  op_r;
    logic [15:0] wdata_r;
    logic [1:0]  off_r;
    logic        accept;
    logic        req_fault;
    logic        req_word_store;
    logic [7:0]  lane_hi, lane_lo;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Read word is big-endian by lane; write word is little-endian by lane.
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign req_ready      = (state == IDLE);
    assign resp_valid     = (state == RESP);
    assign mem_WE         = (state != WRITE);
    assign accept         = req_valid && req_ready;
    assign req_word_store = op[3] && (op[1:0] == 2'b10);

    always_comb begin
        req_fault = 1'b0;
        case (op[1:0])
            2'b01:   req_fault = addr[0];
            2'b10:   req_fault = (addr[1:0] != 2'b00);
            2'b11:   req_fault = 1'b1;
            default: req_fault = 1'b0;
        endcase
    end

    // Lane off is the MSB of a half; a half is always at an even offset.
    always_comb begin
        lane_hi  = mem_RD[{~off_r, 3'b000} +: 8];
        lane_lo  = mem_RD[{~(off_r | 2'b01), 3'b000} +: 8];
        load_val = mem_RD;
        case (op_r[1:0])
            2'b00:   load_val = {{24{~op_r[2] & lane_hi[7]}}, lane_hi};
            2'b01:   load_val = {{16{~op_r[2] & lane_hi[7]}}, lane_hi, lane_lo};
            default: load_val = mem_RD;
        endcase
        merged = mem_RD;
        if (op_r[1:0] == 2'b00) begin
            merged[{~off_r, 3'b000} +: 8] = wdata_r[7:0];
        end else begin
            merged[{~off_r, 3'b000} +: 8]            = wdata_r[15:8];
            merged[{~(off_r | 2'b01), 3'b000} +: 8] = wdata_r[7:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_fault)           state_nx = RESP;
                    else if (req_word_store) state_nx = WRITE;
                    else                     state_nx = READ;
                end
            end
            READ:    state_nx = op_r[3] ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // mem_A/mem_WD change only on edges entering READ or WRITE, never during WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r    <= '0;
            wdata_r <= '0;
            off_r   <= '0;
            fault   <= 1'b0;
            rdata   <= '0;
            mem_A   <= '0;
            mem_WD  <= '0;
        end else begin
            if (accept) begin
                op_r    <= op;
                wdata_r <= wdata[15:0];
                off_r   <= addr[1:0];
                fault   <= req_fault;
                if (!req_fault) mem_A <= {addr[31:2], 2'b00};
                if (!req_fault && req_word_store) mem_WD <= bswap(wdata);
            end
            if (state == READ) begin
                if (op_r[3]) mem_WD <= bswap(merged);
                else         rdata  <= load_val;
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the MEM pipeline register and the byte-addressed `Data_memory`. It accepts one load or store at a time, checks alignment, and drives the word-aligned memory port. Sub-word stores are done as read-modify-write. Load data is returned sign- or zero-extended with a single-cycle response pulse.

## Interface
- No parameters; address and data paths are fixed at 32 bits.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: the pipeline presents an operation.
- `req_ready` out 1: high only in IDLE; the request is accepted when `req_valid && req_ready`.
- `op` in 4: `{is_store, is_unsigned, size[1:0]}`.
  - `size`: 00 = byte, 01 = half, 10 = word, 11 = illegal.
  - `is_unsigned` is ignored for stores and for words.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse that completes the operation.
- `rdata` out 32: extended load result; holds its value until the next load response.
- `fault` out 1: valid with `resp_valid`; set for a misaligned access or illegal size.
- `mem_A` out 32: word-aligned address, always `{addr[31:2],2'b00}`.
- `mem_WD` out 32: write word; byte at `mem_A+k` is carried on `mem_WD[8k+7:8k]`.
- `mem_WE` out 1: memory convention is 0 = write, 1 = read. The idle/default level is 1.
- `mem_RD` in 32: combinational read word; byte at `mem_A+k` is `mem_RD[31-8k:24-8k]` (big-endian).

## Operation
- States: IDLE, READ, WRITE, RESP.
- Accept (in IDLE): latch `op`, `addr`, `wdata`, and the byte offset `off = addr[1:0]`.
- Fault check: the access faults if any of these holds:
  - size 11;
  - half with `off[0]=1`;
  - word with `off≠0`.
- Transitions:
  - IDLE → RESP on a faulted request. No memory access; `fault=1`.
  - IDLE → READ on a load or a byte/half store.
  - IDLE → WRITE on a word store.
  - READ → RESP for a load. `rdata` is extracted from `mem_RD`:
    - byte = lane `off`;
    - half = lanes `off`, `off+1`, with lane `off` as the MSB.
    - Sign-extended unless `is_unsigned`.
  - READ → WRITE for a sub-word store. Register `merged = mem_RD` with the target lanes replaced by `wdata[7:0]` (byte) or `wdata[15:8]`,`wdata[7:0]` (half, MSB at lane `off`).
  - WRITE → RESP. `mem_WE=0` for exactly this cycle.
    - `mem_WD` is `merged`, or `wdata` for a word store, byte-reversed into the memory's write order.
  - RESP → IDLE. `resp_valid=1`; `fault` as latched.
- `mem_A` and `mem_WD` are registered. They are set on the entering edge of READ/WRITE and held stable throughout any cycle where `mem_WE=0`, so the level-sensitive memory never sees a changing address while writing.
- `mem_WE=1` in every state except WRITE.
- `rdata` is unchanged by stores and faults.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready=1`;
  - `resp_valid=0`, `fault=0`;
  - `rdata=0`;
  - `mem_A=0`, `mem_WD=0`, `mem_WE=1`.
- Latency from the accept edge to `resp_valid`, in cycles:
  - load: 2 (READ, RESP);
  - word store: 2 (WRITE, RESP);
  - sub-word store: 3 (READ, WRITE, RESP);
  - fault: 1.
- Throughput: the next request is accepted in the IDLE cycle after RESP. Back-to-back ops therefore have one idle cycle between them.
- `req_valid` while busy is ignored; the upstream holds the request until `req_ready`.
- `resp_valid` and `req_ready` are never high in the same cycle.
- Reset asserted mid-operation: `mem_WE` returns to 1 immediately (asynchronously), the op is dropped, and no `resp_valid` is issued. Reset during WRITE may leave that single word written; there is no partial retry.
- `mem_RD` is sampled at the end of the READ cycle only.

## Test plan
- Word store then load:
  - SW addr=0x10, wdata=0xDEADBEEF → one WRITE cycle, `mem_A=0x10`, `mem_WD=0xEFBEADDE`, `resp_valid` 2 cycles after accept.
  - LW 0x10 with `mem_RD=0xDEADBEEF` → `rdata=0xDEADBEEF`, `fault=0`.
- Byte loads with `mem_RD=0x11F2_3344`:
  - LB 0x21 → `rdata=0xFFFFFFF2`;
  - LBU 0x21 → `0x000000F2`;
  - LH 0x22 → `0x00003344`.
- Sub-word store RMW: memory word = 0x11223344, SB addr=0x32, wdata=0xAB → READ, then WRITE with merged word 0x1122AB44, resp 3 cycles after accept; `mem_WE` low exactly 1 cycle.
- Faults: LW 0x13, LH 0x01, op size 11 → `fault=1` one cycle after accept, `mem_WE` stays 1 throughout, `rdata` unchanged.
- Handshake: hold `req_valid` high with 3 queued ops → each accepted only when `req_ready=1`, no op lost or duplicated, `resp_valid` never overlaps `req_ready`.
- Reset during WRITE of an SH → `mem_WE` rises in the same cycle as `rst`, no `resp_valid`, all outputs at reset values, next LW completes normally.
